// File: rtl/core_pipe_fetch.sv
`default_nettype none
// ============================================================================
// Module   : core_pipe_fetch
// Brief    : Instruction fetch stage. Word reads into a 4-halfword buffer,
//            presents 16/32-bit instructions to decode, services redirects.
// Revision : 1.0
// ============================================================================
module core_pipe_fetch #(
  parameter int          XLEN           = 64,
  parameter logic [XLEN-1:0] FETCH_RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  output logic            imem_req,
  input  logic            imem_gnt,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_recv,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_error,
  output logic            s1_16bit,
  output logic            s1_32bit,
  output logic [31:0]     s1_instr,
  output logic [XLEN-1:0] s1_pc,
  output logic [XLEN-1:0] s1_npc,
  output logic [1:0]      s1_ferr,
  input  logic            s2_eat_2,
  input  logic            s2_eat_4,
  input  logic            s1_cf_valid,
  input  logic [XLEN-1:0] s1_cf_target,
  output logic            s1_cf_ack
);

  localparam int XL = XLEN - 1;
  localparam logic [XL:0] c_pc_two   = XLEN'(2);
  localparam logic [XL:0] c_pc_four  = XLEN'(4);
  localparam logic [XL:0] c_align2   = ~XLEN'(1);
  localparam logic [XL:0] c_align4   = ~XLEN'(3);

  logic [63:0] r_buf;
  logic [3:0]  r_hv;
  logic [3:0]  r_he;
  logic [XL:0] r_pc;
  logic [XL:0] r_faddr;
  logic        r_outstanding;
  logic        r_discard;
  logic        r_drop_lo;
  logic        r_err_stall;
  logic        r_started;

  logic        w_eat4;
  logic        w_eat2;
  logic        w_fire;
  logic        w_append;
  logic        w_owed;
  logic [63:0] w_buf_s;
  logic [3:0]  w_hv_s;
  logic [3:0]  w_he_s;
  logic [XL:0] w_pc_n;
  logic [2:0]  w_slot;
  logic [31:0] w_word;
  logic [3:0]  w_app_hv;
  logic [63:0] w_app_data;
  logic [63:0] w_buf_n;
  logic [3:0]  w_hv_n;
  logic [3:0]  w_he_n;

  function automatic logic [2:0] count4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  // r_started keeps the request low for the first cycle out of reset.
  assign imem_req  = r_started && !r_outstanding && !r_err_stall && (count4(r_hv) <= 3'd2);
  assign imem_addr = r_faddr;

  assign s1_16bit  = r_hv[0] && (r_buf[1:0] != 2'b11);
  assign s1_32bit  = r_hv[0] && r_hv[1] && (r_buf[1:0] == 2'b11);
  assign s1_instr  = r_buf[31:0];
  assign s1_pc     = r_pc;
  assign s1_npc    = r_pc + (s1_32bit ? c_pc_four : c_pc_two);
  assign s1_ferr   = {r_he[1] && s1_32bit, r_he[0]};
  assign s1_cf_ack = s1_cf_valid && !(imem_req && !imem_gnt);

  assign w_eat4   = s2_eat_4 && s1_32bit;
  assign w_eat2   = s2_eat_2 && !s2_eat_4 && s1_16bit;
  assign w_fire   = imem_req && imem_gnt;
  assign w_append = imem_recv && !r_discard;
  assign w_owed   = (r_outstanding && !imem_recv) || w_fire;

  // Invalid buffer slots are kept at zero, so appending is a plain OR.
  always_comb begin
    w_buf_s = r_buf;
    w_hv_s  = r_hv;
    w_he_s  = r_he;
    w_pc_n  = r_pc;
    if (w_eat4) begin
      w_buf_s = {32'b0, r_buf[63:32]};
      w_hv_s  = {2'b0, r_hv[3:2]};
      w_he_s  = {2'b0, r_he[3:2]};
      w_pc_n  = r_pc + c_pc_four;
    end else if (w_eat2) begin
      w_buf_s = {16'b0, r_buf[63:16]};
      w_hv_s  = {1'b0, r_hv[3:1]};
      w_he_s  = {1'b0, r_he[3:1]};
      w_pc_n  = r_pc + c_pc_two;
    end

    w_slot     = count4(w_hv_s);
    w_word     = imem_error ? 32'b0 : imem_rdata;
    w_app_hv   = r_drop_lo ? 4'b0001 : 4'b0011;
    w_app_data = r_drop_lo ? {48'b0, w_word[31:16]} : {32'b0, w_word};

    w_buf_n = w_buf_s;
    w_hv_n  = w_hv_s;
    w_he_n  = w_he_s;
    if (w_append) begin
      w_buf_n = w_buf_s | (w_app_data << {w_slot, 4'b0000});
      w_hv_n  = w_hv_s | (w_app_hv << w_slot);
      if (imem_error) begin
        w_he_n = w_he_s | (w_app_hv << w_slot);
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_buf         <= 64'b0;
      r_hv          <= 4'b0;
      r_he          <= 4'b0;
      r_pc          <= FETCH_RESET_PC;
      r_faddr       <= FETCH_RESET_PC;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_drop_lo     <= 1'b0;
      r_err_stall   <= 1'b0;
      r_started     <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (w_fire) begin
        r_outstanding <= 1'b1;
      end else if (imem_recv) begin
        r_outstanding <= 1'b0;
      end

      if (s1_cf_ack) begin
        r_buf       <= 64'b0;
        r_hv        <= 4'b0;
        r_he        <= 4'b0;
        r_pc        <= s1_cf_target & c_align2;
        r_faddr     <= s1_cf_target & c_align4;
        r_drop_lo   <= s1_cf_target[1];
        r_err_stall <= 1'b0;
        r_discard   <= w_owed;
      end else begin
        r_buf <= w_buf_n;
        r_hv  <= w_hv_n;
        r_he  <= w_he_n;
        r_pc  <= w_pc_n;
        if (w_fire) begin
          r_faddr <= r_faddr + c_pc_four;
        end
        if (imem_recv) begin
          r_discard <= 1'b0;
        end
        if (w_append) begin
          r_drop_lo <= 1'b0;
          if (imem_error) begin
            r_err_stall <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
